// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with writeback mux and retire counter; `WB_BYPASS_EN adds register-file write-through.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic [4:0]  mem_WriteRegister,
  input  logic [31:0] mem_ALUResult,
  input  logic [31:0] mem_ReadData,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic        wb_valid,
  output logic [31:0] retire_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  input  logic [31:0] RegData1,
  input  logic [31:0] RegData2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2
`endif
);
  logic        regWriteQ;
  logic        memtoRegQ;
  logic [31:0] aluResultQ;
  logic [31:0] readDataQ;
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      regWriteQ     <= 1'b0;
      memtoRegQ     <= 1'b0;
      WriteRegister <= 5'd0;
      aluResultQ    <= 32'd0;
      readDataQ     <= 32'd0;
      retire_count  <= 32'd0;
    end else if (flush) begin
      wb_valid  <= 1'b0;
      regWriteQ <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      regWriteQ     <= mem_RegWrite;
      memtoRegQ     <= mem_MemtoReg;
      WriteRegister <= mem_WriteRegister;
      aluResultQ    <= mem_ALUResult;
      readDataQ     <= mem_ReadData;
      retire_count  <= retire_count + {31'd0, mem_valid};
    end
  end
  always_comb begin
    WriteData = memtoRegQ ? readDataQ : aluResultQ;
    RegWrite  = wb_valid & regWriteQ & (|WriteRegister);
  end
`ifdef WB_BYPASS_EN
  always_comb begin
    ReadData1 = (RegWrite && ReadRegister1 == WriteRegister) ? WriteData : RegData1;
    ReadData2 = (RegWrite && ReadRegister2 == WriteRegister) ? WriteData : RegData2;
  end
`endif
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 stall  in  1  hold MEM/WB contents this cycle.
REQ-004 flush  in  1  replace MEM/WB contents with a bubble this cycle.
REQ-005 mem_valid  in  1  MEM-stage slot holds a real instruction.
REQ-006 mem_RegWrite  in  1  instruction writes the register file.
REQ-007 mem_MemtoReg  in  1  1 = write back load data, 0 = write back ALU result.
REQ-008 mem_WriteRegister  in  5  destination register number.
REQ-009 mem_ALUResult  in  32  ALU result from MEM stage.
REQ-010 mem_ReadData  in  32  data-memory read value from MEM stage.
REQ-011 WriteData  out  32  register-file write data.
REQ-012 WriteRegister  out  5  register-file write address.
REQ-013 RegWrite  out  1  register-file write enable.
REQ-014 wb_valid  out  1  WB slot holds a real instruction.
REQ-015 retire_count  out  32  count of instructions loaded into WB with mem_valid=1.

Function
REQ-016 Stage register SHALL capture mem_* fields on the rising edge of clk; latency MEM -> WB outputs exactly 1 cycle.
REQ-017 Update priority SHALL be reset > flush > stall > load.
REQ-018 flush SHALL clear the valid and RegWrite fields; data fields are don't-care. flush and stall together SHALL behave as flush.
REQ-019 stall SHALL hold every stage field and retire_count unchanged. A held write re-asserts RegWrite with identical WriteRegister/WriteData, which is idempotent.
REQ-020 WriteData SHALL equal the registered ReadData when the registered MemtoReg=1, and the registered ALUResult otherwise. This is a combinational mux from the stage flops.
REQ-021 RegWrite SHALL equal wb_valid AND registered RegWrite AND (WriteRegister != 0); writes to register 0 are always suppressed.
REQ-022 A load with mem_valid=0 SHALL produce wb_valid=0 and RegWrite=0 regardless of mem_RegWrite.
REQ-023 retire_count SHALL increment by 1 on each edge where a load occurs (no reset, no flush, no stall) with mem_valid=1. It wraps from 0xFFFFFFFF to 0x00000000.

Reset
REQ-024 On reset: wb_valid=0, RegWrite=0, WriteRegister=0, WriteData=0 (all data/control flops cleared), retire_count=0.
REQ-025 Reset asserted mid-stall or mid-flush SHALL take effect on that edge. The first load SHALL occur on the first edge with reset low.

Configuration
REQ-026 Macro WB_BYPASS_EN: when defined, add ports ReadRegister1/ReadRegister2 (in, 5), RegData1/RegData2 (in, 32; raw register-file outputs) and ReadData1/ReadData2 (out, 32).
REQ-027 With WB_BYPASS_EN: ReadDataN SHALL equal WriteData when RegWrite=1 and ReadRegisterN==WriteRegister, and RegDataN otherwise. This is combinational write-through for same-cycle read-after-write.
REQ-028 Without WB_BYPASS_EN: these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset: assert reset 2 cycles with mem_valid=1 and mem_RegWrite=1 -> RegWrite=0, wb_valid=0, retire_count=0 throughout.
REQ-030 Basic writeback: load mem_valid=1, RegWrite=1, MemtoReg=0, WriteRegister=5, ALUResult=0x12345678 -> next cycle RegWrite=1, WriteRegister=5, WriteData=0x12345678, retire_count=1. Repeat with MemtoReg=1, ReadData=0xDEADBEEF -> WriteData=0xDEADBEEF.
REQ-031 Zero register: load a valid write to register 0 -> RegWrite=0 and wb_valid=1; retire_count still increments.
REQ-032 Stall/flush: stall for 3 cycles while mem_* changes -> outputs and retire_count hold. Then assert flush and stall together -> next cycle wb_valid=0, RegWrite=0, retire_count unchanged.
REQ-033 Wrap: preload retire_count to 0xFFFFFFFF via 2^32-1 loads (or force in the bench), then one valid load -> retire_count=0x00000000.
REQ-034 With WB_BYPASS_EN: WB writes register 7 = 0xA5A5A5A5, ReadRegister1=7, RegData1=0 -> ReadData1=0xA5A5A5A5. With ReadRegister2=0 and the WB write to register 0 suppressed -> ReadData2=RegData2.
